// File: rtl/calc_display_mux.sv
// -----------------------------------------------------------------------------
// calc_display_mux
// Receives the calculator core's digit stream, one BCD digit per clock, into a
// shadow buffer. When the core finishes printing a frame (busy -> ready), the
// whole shadow buffer is copied to the display buffer in one cycle, so a half
// printed number is never shown. The display buffer drives 8 common-anode
// seven-segment digits by time multiplexing.
//
// Ports:
//   clock     in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high
//   status    in   2  core status: 00 error, 01 busy/printing, 10 ready, 11 ignored
//   data      in   4  digit value for position pos
//   pos       in   4  digit position, 0 = least significant, valid 0..7
//   an        out  8  anode enables, active-low, bit i = digit i
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   scan_idx  out  3  index of the digit currently being scanned
//   err_latch out  1  sticky error indicator, cleared only by reset
// -----------------------------------------------------------------------------
module calc_display_mux #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic [2:0] scan_idx,
    output logic       err_latch
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    logic [7:0][3:0]  shadow_r;
    logic [7:0][3:0]  display_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       prev_status_r;
    logic [7:0]       visible_s;
    logic [3:0]       cur_digit_s;
    logic [6:0]       next_seg_s;

    // BCD to active-low gfedcba; F is a minus sign, A..E render blank
    function automatic logic [6:0] decode_digit(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            4'hF:    pattern = 7'b0111111;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Shadow capture while the core prints, whole-frame commit on busy -> ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_r      <= '0;
            display_r     <= '0;
            prev_status_r <= ST_ERROR;
        end else begin
            prev_status_r <= status;
            if (status == ST_BUSY && pos[3] == 1'b0) begin
                shadow_r[pos[2:0]] <= data;
            end
            if (prev_status_r == ST_BUSY && status == ST_READY) begin
                display_r <= shadow_r;
            end
        end
    end

    // Sticky error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_latch <= 1'b0;
        end else if (status == ST_ERROR) begin
            err_latch <= 1'b1;
        end
    end

    // Refresh divider and digit scan pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_r    <= '0;
            scan_idx <= 3'd0;
        end else if (div_r == DIV_LAST) begin
            div_r    <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Leading-zero mask: a digit is visible once any digit at or above it is nonzero
    always_comb begin
        logic seen;
        seen      = 1'b0;
        visible_s = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (display_r[i] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            visible_s[i] = seen || (i == 0) || !BLANK_LEADING;
        end
    end

    // Segment pattern for the digit under the scan pointer
    always_comb begin
        cur_digit_s = display_r[scan_idx];
        next_seg_s  = SEG_BLANK;
        if (err_latch) begin
            case (scan_idx)
                3'd2:       next_seg_s = SEG_E;
                3'd1, 3'd0: next_seg_s = SEG_R;
                default:    next_seg_s = SEG_BLANK;
            endcase
        end else if (visible_s[scan_idx]) begin
            next_seg_s = decode_digit(cur_digit_s);
        end else begin
            next_seg_s = SEG_BLANK;
        end
    end

    // Registered pin drivers, one clock behind the scan pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            an  <= ~(8'b00000001 << scan_idx);
            seg <= next_seg_s;
        end
    end

endmodule

// File: tb/tb_calc_display_mux.sv
module tb_calc_display_mux;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SR = 7'b0101111;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an, an_nb;
    logic [6:0] seg, seg_nb;
    logic [2:0] scan_idx, scan_nb;
    logic       err_latch, err_nb;

    int checks = 0;
    int passes = 0;
    logic [6:0] cap [8];

    calc_display_mux #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .scan_idx(scan_idx), .err_latch(err_latch)
    );

    calc_display_mux #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_nb), .seg(seg_nb), .scan_idx(scan_nb), .err_latch(err_nb)
    );

    always #5 clock = ~clock;

    task automatic write_digit(input logic [3:0] p, input logic [3:0] d);
        status = 2'b01;
        pos    = p;
        data   = d;
        @(negedge clock);
    endtask

    task automatic commit_frame();
        status = 2'b10;
        @(negedge clock);
        @(negedge clock);
    endtask

    // Record the segment pattern seen on each anode over a full scan cycle
    task automatic capture_frame();
        logic [7:0] sel;
        for (int d = 0; d < 8; d++) cap[d] = 7'bxxxxxxx;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            for (int d = 0; d < 8; d++) begin
                sel = ~(8'b00000001 << d);
                if (an == sel) cap[d] = seg;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        logic [2:0] exp_scan;
        logic [6:0] exp_seg;
        reset  = 1'b1;
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        repeat (3) @(negedge clock);
        checks++; if (an !== 8'hFF) $display("FAIL reset_an got %h want ff", an); else passes++;
        checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %b want 1111111", seg); else passes++;
        checks++; if (scan_idx !== 3'd0) $display("FAIL reset_scan got %0d want 0", scan_idx); else passes++;
        checks++; if (err_latch !== 1'b0) $display("FAIL reset_err got %b want 0", err_latch); else passes++;
        reset = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clock);
            exp_an   = ~(8'b00000001 << (((n - 1) / 4) % 8));
            exp_scan = 3'((n / 4) % 8);
            exp_seg  = (((n - 1) / 4) % 8 == 0) ? S0 : SB;
            checks++; if (an !== exp_an) $display("FAIL walk_an n=%0d got %h want %h", n, an, exp_an); else passes++;
            checks++; if (scan_idx !== exp_scan) $display("FAIL walk_scan n=%0d got %0d want %0d", n, scan_idx, exp_scan); else passes++;
            checks++; if (seg !== exp_seg) $display("FAIL walk_seg n=%0d got %b want %b", n, seg, exp_seg); else passes++;
            checks++; if (seg_nb !== S0) $display("FAIL noblank_seg n=%0d got %b want %b", n, seg_nb, S0); else passes++;
        end
    endtask

    task automatic test_capture_commit();
        logic [6:0] exp [8];
        write_digit(4'd0, 4'd3);
        write_digit(4'd1, 4'd2);
        write_digit(4'd2, 4'd1);
        for (int p = 3; p < 8; p++) write_digit(4'(p), 4'd0);
        commit_frame();
        capture_frame();
        exp = '{S3, S2, S1, SB, SB, SB, SB, SB};
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL commit123 digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
    endtask

    task automatic test_no_partial();
        logic [6:0] exp [8];
        write_digit(4'd0, 4'd9);
        repeat (8) @(negedge clock);
        capture_frame();
        exp = '{S3, S2, S1, SB, SB, SB, SB, SB};
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL partial_hidden digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
        commit_frame();
        capture_frame();
        exp = '{S9, S2, S1, SB, SB, SB, SB, SB};
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL commit129 digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
    endtask

    task automatic test_bad_pos();
        logic [6:0] exp [8];
        write_digit(4'd9, 4'd5);
        write_digit(4'd15, 4'd4);
        commit_frame();
        capture_frame();
        exp = '{S9, S2, S1, SB, SB, SB, SB, SB};
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL bad_pos digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
    endtask

    task automatic test_error();
        logic [6:0] exp [8];
        status = 2'b00;
        @(negedge clock);
        checks++; if (err_latch !== 1'b1) $display("FAIL err_set got %b want 1", err_latch); else passes++;
        status = 2'b10;
        @(negedge clock);
        capture_frame();
        exp = '{SR, SR, SE, SB, SB, SB, SB, SB};
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL err_show digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
        write_digit(4'd0, 4'd7);
        commit_frame();
        capture_frame();
        checks++; if (err_latch !== 1'b1) $display("FAIL err_sticky got %b want 1", err_latch); else passes++;
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL err_persist digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] exp [8];
        write_digit(4'd0, 4'd5);
        status = 2'b01;
        pos    = 4'd4;
        data   = 4'd6;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (an !== 8'hFF) $display("FAIL midreset_an got %h want ff", an); else passes++;
        checks++; if (seg !== 7'h7F) $display("FAIL midreset_seg got %b want 1111111", seg); else passes++;
        checks++; if (scan_idx !== 3'd0) $display("FAIL midreset_scan got %0d want 0", scan_idx); else passes++;
        checks++; if (err_latch !== 1'b0) $display("FAIL midreset_err got %b want 0", err_latch); else passes++;
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        @(negedge clock);
        reset = 1'b0;
        capture_frame();
        exp = '{S0, SB, SB, SB, SB, SB, SB, SB};
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL after_reset digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
        write_digit(4'd0, 4'd0);
        commit_frame();
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++; if (cap[d] !== exp[d]) $display("FAIL lost_partial digit%0d got %b want %b", d, cap[d], exp[d]); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_capture_commit();
        test_no_partial();
        test_bad_pos();
        test_error();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
